// File: rtl/custom_fifo_pkg.sv
// Shared constants and Gray-code helpers for the async FIFO control blocks.
package custom_fifo_pkg;

  localparam int FIFO_ADDRSIZE = 4;
  // Helpers work on a wide vector; callers zero-extend their pointer and
  // truncate the result, which is exact for any pointer width up to this.
  localparam int PTR_MAXW = 32;

  function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Prefix XOR from the MSB down; leading zeros of the extension are harmless.
  function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
    logic [PTR_MAXW-1:0] b;
    b = g;
    for (int i = PTR_MAXW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/custom_sync_w2r.sv
// Two-flop synchronizer carrying the Gray write pointer into the read clock.
module custom_sync_w2r #(
  parameter int W = 5
) (
  input  logic         rclk_i,
  input  logic         rrst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] wq1;

  // First stage may go metastable; second stage gives it a cycle to settle.
  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      wq1 <= '0;
      q_o <= '0;
    end else begin
      wq1 <= d_i;
      q_o <= wq1;
    end
  end

endmodule

// File: rtl/custom_fifo_rd_ctrl.sv
// Read-domain control of the async FIFO: read pointers, empty/almost-empty,
// occupancy and underflow, all registered in rclk_i.
module custom_fifo_rd_ctrl
  import custom_fifo_pkg::*;
#(
  parameter int ADDRSIZE = FIFO_ADDRSIZE,
  parameter int AE_LEVEL = 2
) (
  input  logic                rclk_i,
  input  logic                rrst_n_i,
  input  logic [ADDRSIZE:0]   wptr_g_i,
  input  logic                rinc_i,
  output logic [ADDRSIZE-1:0] raddr_o,
  output logic [ADDRSIZE:0]   rptr_g_o,
  output logic                rempty_o,
  output logic                ralmost_empty_o,
  output logic [ADDRSIZE:0]   rcount_o,
  output logic                runderflow_o
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wq2;
  logic [PW-1:0] rbin, rbin_next, rgray_next, wbin_s, cnt_next;
  logic          ren, ae_next;

  custom_sync_w2r #(.W(PW)) u_sync (
    .rclk_i   (rclk_i),
    .rrst_n_i (rrst_n_i),
    .d_i      (wptr_g_i),
    .q_o      (wq2)
  );

  // Next-pointer and flag computation; empty/count look at this cycle's
  // post-pop pointer so a draining pop raises empty on the same edge.
  always_comb begin
    ren        = rinc_i & ~rempty_o;
    rbin_next  = rbin + PW'(ren);
    rgray_next = PW'(bin2gray(PTR_MAXW'(rbin_next)));
    wbin_s     = PW'(gray2bin(PTR_MAXW'(wq2)));
    cnt_next   = wbin_s - rbin_next;
    ae_next    = int'(cnt_next) <= AE_LEVEL;
  end

  // Pointer and status registers; empty resets high so nothing pops early.
  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      rbin            <= '0;
      rptr_g_o        <= '0;
      rempty_o        <= 1'b1;
      ralmost_empty_o <= 1'b1;
      rcount_o        <= '0;
      runderflow_o    <= 1'b0;
    end else begin
      rbin            <= rbin_next;
      rptr_g_o        <= rgray_next;
      rempty_o        <= (rgray_next == wq2);
      ralmost_empty_o <= ae_next;
      rcount_o        <= cnt_next;
      runderflow_o    <= rinc_i & rempty_o;
    end
  end

  assign raddr_o = rbin[ADDRSIZE-1:0];

endmodule
